// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_padder
// Purpose  : Producer side of the SHA-256 block input. Collects 32-bit message
//            words, applies SHA-256 padding (0x80, zero fill, 64-bit
//            big-endian bit length) and presents complete 512-bit blocks.
//            Word 0 of a block is blk_data[511:480]; byte 0 of a word is
//            bits [31:24].
// Ports    : clk        - clock, rising edge
//            reset_n    - asynchronous active-low reset
//            in_valid   - in_data/in_last/in_nbytes valid
//            in_ready   - padder accepts a word this cycle (FILL state)
//            in_data    - message word, big-endian bytes
//            in_last    - final word of the message
//            in_nbytes  - valid bytes in the last word (0..4), 4 otherwise
//            blk_valid  - blk_data holds a complete block
//            blk_ready  - consumer takes the block
//            blk_data   - padded block, word 0 at the MSBs
//            blk_first  - block is the first of its message
//            blk_last   - block is the final, length-carrying block
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_nbytes,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_first,
   output logic         blk_last
);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_PAD  = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   localparam logic [31:0] c_MARK_WORD = 32'h8000_0000;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_buf [16];
   logic [31:0]        w_pad_buf [16];
   logic [3:0]         r_widx;
   logic [LEN_W-1:0]   r_count;
   logic [4:0]         r_p;         // first word the PAD cycle rewrites (0..16)
   logic               r_put80;     // PAD writes 0x80000000 at word r_p
   logic               r_pend_80;   // marker still owed to a following block
   logic               r_pend_len;  // length still owed to a following block
   logic               r_blk_first;
   logic               r_blk_last;
   logic               w_in_fire;
   logic               w_blk_fire;
   logic               w_pend;
   logic [31:0]        w_last_word;
   logic [63:0]        w_len;

   assign in_ready   = (r_state == S_FILL);
   assign blk_valid  = (r_state == S_EMIT);
   assign blk_first  = r_blk_first;
   assign blk_last   = r_blk_last;
   assign w_in_fire  = in_valid && in_ready;
   assign w_blk_fire = blk_valid && blk_ready;
   assign w_pend     = r_pend_80 || r_pend_len;
   assign w_len      = 64'(r_count) << 3;

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         blk_data[511 - 32*i -: 32] = r_buf[i];
      end
   end

   // Short last word: drop the unused bytes and drop the 0x80 marker straight
   // into the first free byte. A full last word leaves the marker to PAD.
   always_comb begin
      case (in_nbytes)
         3'd0:    w_last_word = c_MARK_WORD;
         3'd1:    w_last_word = {in_data[31:24], 24'h80_0000};
         3'd2:    w_last_word = {in_data[31:16], 16'h8000};
         3'd3:    w_last_word = {in_data[31:8], 8'h80};
         default: w_last_word = in_data;
      endcase
   end

   // Words below r_p are message data; word r_p either already holds the
   // marker or receives it; everything after is zero, with the length in
   // words 14/15 when both still fit.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < r_p) begin
            w_pad_buf[i] = r_buf[i];
         end else if (5'(i) == r_p) begin
            w_pad_buf[i] = r_put80 ? c_MARK_WORD : r_buf[i];
         end else begin
            w_pad_buf[i] = '0;
         end
      end
      if (r_p <= 5'd13) begin
         w_pad_buf[14] = w_len[63:32];
         w_pad_buf[15] = w_len[31:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL: begin
            if (w_in_fire) begin
               if (in_last) begin
                  w_state_nxt = S_PAD;
               end else if (r_widx == 4'd15) begin
                  w_state_nxt = S_EMIT;
               end
            end
         end
         S_PAD:  w_state_nxt = S_EMIT;
         S_EMIT: begin
            if (w_blk_fire) begin
               w_state_nxt = (r_blk_last || !w_pend) ? S_FILL : S_PAD;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            r_buf[i] <= '0;
         end
         r_widx      <= '0;
         r_count     <= '0;
         r_p         <= '0;
         r_put80     <= 1'b0;
         r_pend_80   <= 1'b0;
         r_pend_len  <= 1'b0;
         r_blk_first <= 1'b1;
         r_blk_last  <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_in_fire) begin
                  r_count <= r_count + LEN_W'(in_nbytes);
                  if (in_last) begin
                     r_buf[r_widx] <= w_last_word;
                     r_p           <= {1'b0, r_widx} + 5'(in_nbytes == 3'd4);
                     r_put80       <= (in_nbytes == 3'd4);
                  end else begin
                     r_buf[r_widx] <= in_data;
                     if (r_widx == 4'd15) begin
                        r_blk_last <= 1'b0;
                        r_pend_80  <= 1'b0;
                        r_pend_len <= 1'b0;
                     end else begin
                        r_widx <= r_widx + 4'd1;
                     end
                  end
               end
            end
            S_PAD: begin
               for (int i = 0; i < 16; i++) begin
                  r_buf[i] <= w_pad_buf[i];
               end
               if (r_p <= 5'd13) begin
                  r_blk_last <= 1'b1;
                  r_pend_80  <= 1'b0;
                  r_pend_len <= 1'b0;
               end else begin
                  r_blk_last <= 1'b0;
                  r_pend_len <= 1'b1;
                  r_pend_80  <= (r_p == 5'd16);
               end
            end
            S_EMIT: begin
               if (w_blk_fire) begin
                  r_widx <= '0;
                  if (r_blk_last) begin
                     r_count     <= '0;
                     r_blk_first <= 1'b1;
                     r_blk_last  <= 1'b0;
                  end else begin
                     r_blk_first <= 1'b0;
                     if (w_pend) begin
                        // Padding-only block: start from a clean buffer.
                        for (int i = 0; i < 16; i++) begin
                           r_buf[i] <= '0;
                        end
                        r_p        <= '0;
                        r_put80    <= r_pend_80;
                        r_pend_80  <= 1'b0;
                        r_pend_len <= 1'b0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
